seg_digit_scanner: RTL and testbench
====================================

// Module: seg_digit_scanner
// PURPOSE
//   Time-multiplexes a NUM_DIGITS-wide hex value onto a common-anode multi-digit
//   seven-segment display. Feeds the single BCD/hex-to-segment decoder downstream,
//   one nibble at a time, and drives the active-low digit anodes.
//   Values written by the CPU/debug path are double-buffered and applied only at
//   frame boundaries, so a displayed frame never tears.
// PARAMETERS
//   NUM_DIGITS   8      number of digits scanned; legal range 2..8
//   REFRESH_DIV  50000  clk cycles per digit slot; minimum 2 (50 MHz -> 1 kHz/digit)
// PORTS
//   clk          in   1              single system clock, rising edge
//   rst          in   1              synchronous, active-high reset
//   in_value     in   4*NUM_DIGITS   hex value to show; nibble k -> digit k (digit 0 = LSN)
//   in_load      in   1              1-cycle strobe; captures in_value into pending buffer
//   in_blank     in   1              1 = all anodes off (level, combinational on out_an)
//   out_bcd      out  4              nibble of the active digit -> segment decoder in_bcd
//   out_an       out  NUM_DIGITS     anode enables, active-low, one-hot-low when shown
//   out_pending  out  1              1 = a loaded value is waiting for the next frame
//   out_frame    out  1              1-cycle pulse when the digit index wraps to 0
// BEHAVIOUR
//   - Registers: div_cnt (clog2 REFRESH_DIV), dig_idx (clog2 NUM_DIGITS),
//     pend_val/pend_vld, shadow (4*NUM_DIGITS).
//   - Reset: div_cnt=0, dig_idx=0, shadow=0, pend_vld=0, pend_val=0;
//     outputs: out_bcd=0, out_an=~1 (digit 0 on, unless in_blank), out_pending=0, out_frame=0.
//   - tick = (div_cnt == REFRESH_DIV-1). div_cnt increments each cycle, returns to 0 on tick.
//   - On tick: dig_idx <= (dig_idx == NUM_DIGITS-1) ? 0 : dig_idx+1.
//   - wrap = tick && dig_idx == NUM_DIGITS-1. out_frame registered: high the cycle
//     dig_idx becomes 0.
//   - in_load: pend_val <= in_value, pend_vld <= 1 at the next edge.
//   - On wrap with pend_vld=1: shadow <= pend_val. pend_vld clears, unless in_load is
//     asserted in the same cycle; then pend_val takes the new in_value, pend_vld stays 1,
//     and the new value is applied at the following wrap.
//   - Load with pend_vld already 1 and no wrap: pend_val is overwritten; last write wins.
//   - out_bcd = shadow[4*dig_idx +: 4]. It is a registered index with a combinational
//     select, so it changes on the same edge as out_an.
//   - out_an[k] = ~(k == dig_idx) | in_blank. in_blank does not stop scanning or loading.
//   - out_pending = pend_vld.
//   - Mid-operation rst: all state returns to reset values at that edge; the pending value
//     is discarded.
//   - First shadow update after reset happens at the first wrap, which is
//     NUM_DIGITS*REFRESH_DIV cycles after reset release.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined:
//     - lead = index of the most-significant nonzero nibble of shadow (0 if shadow==0).
//     - For dig_idx > lead, out_an is all ones (digit dark). Digit 0 is always lit.
//     - The scan timing is unchanged.
//   Not defined:
//     - Every digit is lit in turn; leading zeros are displayed as '0'.
// TESTING  (bench: NUM_DIGITS=4, REFRESH_DIV=4)
//   1. Reset, then idle 64 cycles.
//      -> out_an steps 1110,1101,1011,0111 every 4 clk; out_bcd=0.
//      -> out_frame pulses every 16 clk.
//   2. Pulse in_load with in_value=16'hA5C3 mid-frame.
//      -> out_pending=1 next cycle; the old digits are held until the wrap.
//      -> Then digits 0..3 show out_bcd 3,C,5,A and out_pending=0.
//   3. Load 16'h1111, then 16'h2222 before the wrap.
//      -> Only 2222 is ever displayed.
//   4. in_load in the exact wrap cycle, with 16'h1234 pending and in_value=16'h9876.
//      -> Frame N+1 shows 1234 with out_pending=1; frame N+2 shows 9876.
//   5. Hold in_blank=1 for 20 cycles.
//      -> out_an=1111 throughout; dig_idx keeps advancing.
//      -> Release resumes on the correct digit.
//   6. Assert rst at dig_idx=2 with a load pending.
//      -> Next cycle out_an=1110, out_pending=0.
//      -> With LEADING_ZERO_BLANK_EN and shadow=16'h0042: digits 2,3 dark; 0,1 lit.

Source files
------------

// File: rtl/seg_digit_scanner_if.sv
// seg_digit_scanner_if: value/load/blank inputs and scanned display outputs of the digit scanner
interface seg_digit_scanner_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] in_value;
  logic                    in_load;
  logic                    in_blank;
  logic [3:0]              out_bcd;
  logic [NUM_DIGITS-1:0]   out_an;
  logic                    out_pending;
  logic                    out_frame;
  modport master (
    output in_value, in_load, in_blank,
    input  out_bcd, out_an, out_pending, out_frame
  );
  modport slave (
    input  in_value, in_load, in_blank,
    output out_bcd, out_an, out_pending, out_frame
  );
endinterface

// File: rtl/seg_digit_scanner.sv
// seg_digit_scanner: frame-synchronous double-buffered multi-digit 7-seg scanner (optional LEADING_ZERO_BLANK_EN)
module seg_digit_scanner #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  seg_digit_scanner_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [IW-1:0] dig_idx_q, dig_idx_d;
  logic [VW-1:0] pend_val_q, pend_val_d;
  logic          pend_vld_q, pend_vld_d;
  logic [VW-1:0] shadow_q, shadow_d;
  logic          frame_q, frame_d;
  logic          tick, wrap, dark;
  logic [NUM_DIGITS-1:0] sel;
  always_comb begin
    tick       = div_cnt_q == CW'(REFRESH_DIV - 1);
    wrap       = tick && dig_idx_q == IW'(NUM_DIGITS - 1);
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    dig_idx_d  = !tick ? dig_idx_q : wrap ? '0 : dig_idx_q + 1'b1;
    shadow_d   = (wrap && pend_vld_q) ? pend_val_q : shadow_q;
    pend_val_d = bus.in_load ? bus.in_value : pend_val_q;
    // a load in the wrap cycle keeps the buffer armed for the following frame
    pend_vld_d = bus.in_load | (pend_vld_q & ~wrap);
    frame_d    = wrap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      dig_idx_q  <= '0;
      pend_val_q <= '0;
      pend_vld_q <= 1'b0;
      shadow_q   <= '0;
      frame_q    <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      dig_idx_q  <= dig_idx_d;
      pend_val_q <= pend_val_d;
      pend_vld_q <= pend_vld_d;
      shadow_q   <= shadow_d;
      frame_q    <= frame_d;
    end
  end
`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] lead;
  always_comb begin
    lead = '0;
    for (int k = 1; k < NUM_DIGITS; k++)
      lead = (shadow_q[4*k +: 4] != 4'h0) ? IW'(k) : lead;
    dark = dig_idx_q > lead;
  end
`else
  always_comb dark = 1'b0;
`endif
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      sel[k] = dig_idx_q == IW'(k);
  end
  assign bus.out_bcd     = shadow_q[{dig_idx_q, 2'b00} +: 4];
  assign bus.out_an      = (bus.in_blank || dark) ? '1 : ~sel;
  assign bus.out_pending = pend_vld_q;
  assign bus.out_frame   = frame_q;
endmodule

// File: tb/tb_seg_digit_scanner.sv
// tb_seg_digit_scanner: directed bench with a cycle-count display model checked every cycle
module tb_seg_digit_scanner;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FR = ND * RD;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  seg_digit_scanner_if #(.NUM_DIGITS(ND)) bus ();
  seg_digit_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: cycles since reset, what is shown, and what is waiting
  int m_t = 0;
  logic [4*ND-1:0] m_sh = '0;
  logic [4*ND-1:0] m_pval = '0;
  logic m_pv = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      m_t = 0;
      m_sh = '0;
      m_pval = '0;
      m_pv = 1'b0;
    end else begin
      if (m_t % FR == FR - 1 && m_pv) begin
        m_sh = m_pval;
        m_pv = 1'b0;
      end
      if (bus.in_load) begin
        m_pval = bus.in_value;
        m_pv = 1'b1;
      end
      m_t++;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      automatic int dig = (m_t / RD) % ND;
      automatic logic [ND-1:0] e_an = ~(ND'(1) << dig);
`ifdef LEADING_ZERO_BLANK_EN
      automatic int lead = 0;
      while (lead < ND - 1 && (m_sh >> (4 * (lead + 1))) != 0) lead++;
      if (dig > lead) e_an = '1;
`endif
      if (bus.in_blank) e_an = '1;
      chk("model_an", bus.out_an, e_an);
      chk("model_bcd", bus.out_bcd, (m_sh >> (4 * dig)) & 4'hF);
      chk("model_pending", bus.out_pending, m_pv);
      chk("model_frame", bus.out_frame, (m_t % FR == 0 && m_t != 0) ? 1 : 0);
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_frame && n < 3 * FR);
    chk("frame_wait", bus.out_frame, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int cnt;
    logic [3:0] exp_a5[4];
    exp_a5[0] = 4'h3; exp_a5[1] = 4'hC; exp_a5[2] = 4'h5; exp_a5[3] = 4'hA;
    bus.in_value = '0;
    bus.in_load = 1'b0;
    bus.in_blank = 1'b0;
    step();
    chk_en = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_an", bus.out_an, 4'b1110);
    chk("rst_bcd", bus.out_bcd, 0);
    chk("rst_pending", bus.out_pending, 0);
    chk("rst_frame", bus.out_frame, 0);
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.out_frame) cnt++;
      if (i == 4) chk("idle_an_d1", bus.out_an, 4'b1101);
      if (i == 11) chk("idle_an_d3", bus.out_an, 4'b0111);
    end
    chk("idle_frames", cnt, 4);
    step();
    bus.in_value = 16'hA5C3;
    bus.in_load = 1'b1;
    step();
    bus.in_load = 1'b0;
    @(negedge clk);
    chk("load_pending", bus.out_pending, 1);
    chk("load_old_held", bus.out_bcd, 0);
    wait_frame();
    chk("a5c3_pending", bus.out_pending, 0);
    chk("a5c3_d0", bus.out_bcd, exp_a5[0]);
    for (int d = 1; d < ND; d++) begin
      repeat (RD) @(negedge clk);
      chk("a5c3_dn", bus.out_bcd, exp_a5[d]);
    end
    wait_frame();
    step();
    bus.in_value = 16'h1111;
    bus.in_load = 1'b1;
    step();
    bus.in_load = 1'b0;
    repeat (3) step();
    bus.in_value = 16'h2222;
    bus.in_load = 1'b1;
    step();
    bus.in_load = 1'b0;
    wait_frame();
    cnt = 0;
    for (int i = 0; i < FR; i++) begin
      if (bus.out_bcd == 4'h2) cnt++;
      @(negedge clk);
    end
    chk("last_write_wins", cnt, FR);
    step();
    bus.in_value = 16'h1234;
    bus.in_load = 1'b1;
    step();
    bus.in_load = 1'b0;
    repeat (13) step();
    bus.in_value = 16'h9876;
    bus.in_load = 1'b1;
    step();
    bus.in_load = 1'b0;
    @(negedge clk);
    chk("wrapload_frame", bus.out_frame, 1);
    chk("wrapload_pending", bus.out_pending, 1);
    chk("wrapload_bcd_1234", bus.out_bcd, 4'h4);
    wait_frame();
    chk("next_bcd_9876", bus.out_bcd, 4'h6);
    chk("next_pending", bus.out_pending, 0);
    step();
    bus.in_blank = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_an == 4'hF) cnt++;
    end
    chk("blank_cycles", cnt, 20);
    step();
    bus.in_blank = 1'b0;
    @(negedge clk);
    chk("blank_resume_an", bus.out_an, 4'b1101);
    wait_frame();
    step();
    bus.in_value = 16'h5555;
    bus.in_load = 1'b1;
    step();
    bus.in_load = 1'b0;
    repeat (7) step();
    @(negedge clk);
    chk("pre_rst_an", bus.out_an, 4'b1011);
    chk("pre_rst_pending", bus.out_pending, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_an", bus.out_an, 4'b1110);
    chk("midrst_pending", bus.out_pending, 0);
    wait_frame();
    chk("midrst_discard", bus.out_bcd, 0);
`ifdef LEADING_ZERO_BLANK_EN
    step();
    bus.in_value = 16'h0042;
    bus.in_load = 1'b1;
    step();
    bus.in_load = 1'b0;
    wait_frame();
    cnt = 0;
    for (int i = 0; i < FR; i++) begin
      if (bus.out_an == 4'hF) cnt++;
      @(negedge clk);
    end
    chk("lzb_dark_cycles", cnt, 2 * RD);
`endif
    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
